display_scan_ctrl: RTL and testbench
====================================

# display_scan_ctrl

Time-multiplexed display scan controller for the stopwatch's 4-digit display. It generates the 2-bit select that steers the 4:1 14-bit digit-word multiplexer and captures the selected word on `word_in`. It drives the captured segment pattern and an active-low one-hot digit enable at a programmable refresh rate. It is the consumer/driver end of the digit-select interface: it owns `sel`, and the mux only answers it.

## Interface
Parameters:
- `DIV`, 50000: HOLD length in clocks per digit (≥2).
- `BLANK_CYC`, 4: inter-digit blanking length in clocks (≥1; used only with `SCAN_BLANK_EN`).
- `CW`, `$clog2(DIV)`: prescaler width.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: **asynchronous, active-high** reset.
- `en`, in, 1: scan enable; low forces IDLE.
- `word_in`, in, 14: selected digit word returned by the mux.
- `sel`, out, 2: digit select to the mux (registered).
- `seg`, out, 14: latched segment pattern (registered).
- `an`, out, 4: digit enables, active-low, one-hot-low or all-ones.
- `frame_tick`, out, 1: one-cycle pulse when the digit index wraps 3→0.

## Operation
- Reset values: `sel`=2'b00, `seg`=14'h0000, `an`=4'b1111, `frame_tick`=0, state=IDLE, digit=0, prescaler=0.
- **IDLE:** outputs are held at reset values. Moves to SEL the cycle after `en`=1.
- **SEL (1 cycle):** `sel` is set to `digit`, and `an`=4'b1111.
  - On exit: `seg` latches `word_in`, and `an` is set to `~(4'b0001 << digit)`.
  - `word_in` is sampled one cycle after `sel` changes. The mux is therefore never sampled in the cycle its select changes.
- **HOLD (DIV cycles):** the prescaler counts 0..DIV-1, and `seg`/`an` stay stable.
  - At terminal count the block enters BLANK (macro on) or advances (macro off).
- **BLANK (BLANK_CYC cycles):** `an`=4'b1111, and `seg` keeps its value.
- **Advance:** `digit`=`digit`+1, wrapping mod 4, then the block enters SEL.
  - `frame_tick`=1 for exactly the one cycle in which `digit` goes 3→0.
- `en` falling in any state: the next state is IDLE. The outputs return to reset values on that clock edge, and `digit` and the prescaler clear.
- `en` rising again: the scan always restarts at digit 0.
- `rst` asserted mid-operation: all outputs take reset values immediately (asynchronously). Scanning resumes at digit 0 in SEL on the second rising edge after release if `en`=1.
- `word_in` changes during HOLD are ignored until that digit's next SEL.

## Timing
- Digit period is 1+DIV+BLANK_CYC clocks with the macro, and 1+DIV without it.
- Frame period is 4× the digit period.
- `sel`→capture latency is 1 clock. Capture→`an` active is 0 clocks: both update on the same edge.
- An `an` bit is never low in a cycle where `sel` differs from the index of that bit.
- Two `an` bits are never low in the same cycle.
- With the macro, there is no cycle in which `an` changes directly from one active digit to another.

## Configuration
- `SCAN_BLANK_EN` defined: the BLANK state and `BLANK_CYC` are compiled in, and blanking is 1+BLANK_CYC clocks (SEL plus BLANK).
- Undefined: there is no BLANK state, HOLD goes directly to advance, and the only blanking is the 1-cycle SEL. `BLANK_CYC` is ignored.

## Structure
- Shared package `stopwatch_pkg`:
  - `NUM_DIGITS`=4, `WORD_W`=14.
  - `scan_state_t` enum {IDLE, SEL, HOLD, BLANK}.
  - `AN_OFF`=4'b1111.
- One sub-module, `scan_prescaler`: a terminal counter with clear and enable that outputs `tc`. It is reused for both HOLD and BLANK, reloaded on state entry.

## Test plan
- **Reset/idle:** with `rst`=1, `en`=0 → `an`=4'hF, `seg`=0, `sel`=0, `frame_tick`=0. Hold these for 20 cycles after release.
- **Basic scan** (DIV=4, BLANK_CYC=2, macro on), mux model with `word_in`=14'h0011/0022/0033/0044 for `sel` 0..3:
  - `an` sequence is 1110, 1101, 1011, 0111, each low for 4 cycles, with `seg` showing the matching word.
  - Digit period is 7 clocks, and `frame_tick` pulses once every 28 clocks.
- **Macro off**, same stimulus → digit period 5 clocks, frame 20 clocks, no BLANK state entered.
- **Late word change:** change the mux output for `sel`=1 from 14'h0022 to 14'h3FFF mid-HOLD of digit 1 → `seg` stays 14'h0022 until digit 1's next SEL, then shows 14'h3FFF.
- **`en` drop** in HOLD of digit 2 → next cycle `an`=4'hF and `seg`=0. On re-enable, the first active `an` is 1110.
- **Async reset** asserted mid-HOLD, between clock edges → outputs reach reset values before the next edge, and scanning restarts at digit 0.

Source files
------------

// File: rtl/stopwatch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stopwatch_pkg                                                        |
// | Shared types and constants for the stopwatch display path.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package stopwatch_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam int         WORD_W     = 14;
  localparam logic [3:0] AN_OFF     = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEL   = 2'd1,
    HOLD  = 2'd2,
    BLANK = 2'd3
  } scan_state_t;

  // Active-low one-hot enable for the given digit index.
  function automatic logic [3:0] an_for_digit(input logic [1:0] digit);
    logic [3:0] onehot;
    onehot = 4'b0001 << digit;
    return ~onehot;
  endfunction

endpackage
`default_nettype wire

// File: rtl/scan_prescaler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scan_prescaler                                                       |
// | Terminal counter 0..last with clear and enable; wraps to 0 on tc.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module scan_prescaler #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tc = en && (cnt_q == last);

  // Idle or terminal count reloads zero, so the next user starts fresh.
  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clr || !en || tc) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | display_scan_ctrl                                                    |
// | 4-digit time-multiplexed scan: drives sel, captures word_in, drives  |
// | seg/an. Define SCAN_BLANK_EN to add inter-digit BLANK state.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module display_scan_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 4,
  parameter int CW        = $clog2(DIV)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [13:0] word_in,
  output logic [1:0]  sel,
  output logic [13:0] seg,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int BW = $clog2(BLANK_CYC + 1);
  localparam int PW = (CW > BW) ? CW : BW;

  scan_state_t state_q, state_d;
  logic [1:0]  digit_q, digit_d;
  logic [1:0]  sel_q, sel_d;
  logic [13:0] seg_q, seg_d;
  logic [3:0]  an_q, an_d;
  logic        frame_tick_q, frame_tick_d;
  logic        run_ok_q, run_ok_d;

  logic          presc_en;
  logic          presc_tc;
  logic [PW-1:0] presc_last;
  logic [1:0]    next_digit;

  assign presc_en   = (state_q == HOLD) || (state_q == BLANK);
  assign presc_last = (state_q == BLANK) ? PW'(BLANK_CYC - 1) : PW'(DIV - 1);
  assign next_digit = digit_q + 2'd1;

  scan_prescaler #(
    .W (PW)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (~en),
    .en   (presc_en),
    .last (presc_last),
    .tc   (presc_tc)
  );

  always_comb begin
    state_d      = state_q;
    digit_d      = digit_q;
    sel_d        = sel_q;
    seg_d        = seg_q;
    an_d         = an_q;
    frame_tick_d = 1'b0;
    run_ok_d     = 1'b1;

    if (!en) begin
      state_d = IDLE;
      digit_d = 2'd0;
      sel_d   = 2'd0;
      seg_d   = '0;
      an_d    = AN_OFF;
    end else begin
      case (state_q)
        IDLE: begin
          // One settling edge after reset release before the first SEL.
          if (run_ok_q) begin
            state_d = SEL;
            sel_d   = digit_q;
            an_d    = AN_OFF;
          end
        end
        SEL: begin
          state_d = HOLD;
          seg_d   = word_in;
          an_d    = an_for_digit(digit_q);
        end
        HOLD: begin
          if (presc_tc) begin
`ifdef SCAN_BLANK_EN
            state_d = BLANK;
            an_d    = AN_OFF;
`else
            state_d      = SEL;
            digit_d      = next_digit;
            sel_d        = next_digit;
            an_d         = AN_OFF;
            frame_tick_d = (digit_q == 2'd3);
`endif
          end
        end
        BLANK: begin
`ifdef SCAN_BLANK_EN
          if (presc_tc) begin
            state_d      = SEL;
            digit_d      = next_digit;
            sel_d        = next_digit;
            an_d         = AN_OFF;
            frame_tick_d = (digit_q == 2'd3);
          end
`else
          state_d = IDLE;
          digit_d = 2'd0;
          sel_d   = 2'd0;
          seg_d   = '0;
          an_d    = AN_OFF;
`endif
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      digit_q      <= 2'd0;
      sel_q        <= 2'd0;
      seg_q        <= '0;
      an_q         <= AN_OFF;
      frame_tick_q <= 1'b0;
      run_ok_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      digit_q      <= digit_d;
      sel_q        <= sel_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
      run_ok_q     <= run_ok_d;
    end
  end

  assign sel        = sel_q;
  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_display_scan_ctrl                                                 |
// | Directed bench for display_scan_ctrl with a 4:1 mux model.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_display_scan_ctrl;

  localparam int DIV       = 4;
  localparam int BLANK_CYC = 2;
`ifdef SCAN_BLANK_EN
  localparam int BLK = BLANK_CYC;
`else
  localparam int BLK = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [13:0] word_in;
  logic [1:0]  sel;
  logic [13:0] seg;
  logic [3:0]  an;
  logic        frame_tick;

  logic [13:0] mux [4];
  assign word_in = mux[sel];

  int checks   = 0;
  int failures = 0;

  display_scan_ctrl #(
    .DIV       (DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .word_in    (word_in),
    .sel        (sel),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_off(input string tag);
    chk({tag, "_an"}, an, 4'hF);
    chk({tag, "_seg"}, seg, 14'h0000);
    chk({tag, "_sel"}, sel, 2'd0);
    chk({tag, "_ft"}, frame_tick, 1'b0);
  endtask

  // Entered in the SEL cycle of digit d; leaves in the next digit's SEL cycle.
  task automatic scan_digit(input int d, input logic [13:0] w, input logic ft,
                            input int chg_at, input logic [13:0] chg_w);
    logic [3:0] ea;
    ea = 4'b0001 << d;
    ea = ~ea;
    chk("sel_sel", sel, d);
    chk("sel_an", an, 4'hF);
    chk("sel_ft", frame_tick, ft);
    for (int i = 0; i < DIV; i++) begin
      step();
      chk("hold_an", an, ea);
      chk("hold_seg", seg, w);
      chk("hold_sel", sel, d);
      chk("hold_ft", frame_tick, 1'b0);
      if (i == chg_at) mux[d] = chg_w;
    end
    for (int i = 0; i < BLK; i++) begin
      step();
      chk("blank_an", an, 4'hF);
      chk("blank_seg", seg, w);
    end
    step();
  endtask

  initial begin
    mux[0] = 14'h0011;
    mux[1] = 14'h0022;
    mux[2] = 14'h0033;
    mux[3] = 14'h0044;

    // Reset and idle
    repeat (2) step();
    chk_off("rst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk_off("idle");
    end

    // Basic scan: one full frame, then the wrap tick on digit 0
    en = 1'b1;
    step();
    scan_digit(0, 14'h0011, 1'b0, -1, 14'h0);
    scan_digit(1, 14'h0022, 1'b0, -1, 14'h0);
    scan_digit(2, 14'h0033, 1'b0, -1, 14'h0);
    scan_digit(3, 14'h0044, 1'b0, -1, 14'h0);
    scan_digit(0, 14'h0011, 1'b1, -1, 14'h0);

    // Late word change mid-HOLD of digit 1
    scan_digit(1, 14'h0022, 1'b0, 1, 14'h3FFF);
    scan_digit(2, 14'h0033, 1'b0, -1, 14'h0);
    scan_digit(3, 14'h0044, 1'b0, -1, 14'h0);
    scan_digit(0, 14'h0011, 1'b1, -1, 14'h0);
    scan_digit(1, 14'h3FFF, 1'b0, -1, 14'h0);

    // en drop in HOLD of digit 2
    step();
    chk("drop_hold_an", an, 4'b1011);
    chk("drop_hold_seg", seg, 14'h0033);
    step();
    en = 1'b0;
    step();
    chk_off("drop");
    step();
    chk_off("drop_idle");
    en = 1'b1;
    step();
    scan_digit(0, 14'h0011, 1'b0, -1, 14'h0);

    // Async reset mid-HOLD of digit 1, between edges
    step();
    chk("pre_rst_an", an, 4'b1101);
    #2;
    rst = 1'b1;
    #1;
    chk_off("async_rst");
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("rel1_an", an, 4'hF);
    step();
    scan_digit(0, 14'h0011, 1'b0, -1, 14'h0);
    chk("rel_next_sel", sel, 2'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
